// File: rtl/cnn_stream_pkg.sv
// Shared types for the CNN streaming stages: sample width, the {data,last}
// beat carried between stages, and a signed max helper.
package cnn_stream_pkg;

    localparam int T = 16;

    typedef logic signed [T-1:0] sample_t;

    typedef struct packed {
        sample_t data;
        logic    last;
    } beat_t;

    function automatic sample_t smax(sample_t a, sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_1d_stream_skid_buf2.sv
// Two-entry skid buffer for beat_t with a registered ready, so upstream never
// sees a combinational path from the downstream ready.
module skid_buf2
    import cnn_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [T:0] push_beat,
    output logic       ready,
    output logic       m_valid,
    output logic [T:0] m_beat,
    input  logic       m_ready
);

    beat_t      slot0_q, slot0_d;
    beat_t      slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       ready_q, ready_d;
    logic       pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // slot0 is always the head; a push never arrives while both slots are full
    // because the producer only pushes on an edge where ready was high.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        pop     = (count_q != 2'd0) && m_ready;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = push_beat;
                else                 slot1_d = push_beat;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_beat;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_beat;
                end
            end
            default: ;
        endcase
        ready_d = (count_d != 2'd2);
    end

    always_comb begin
        ready   = ready_q;
        m_valid = (count_q != 2'd0);
        m_beat  = m_valid ? slot0_q : '0;
    end

endmodule

// File: rtl/maxpool_1d_stream.sv
// Streaming 1-D max-pool: non-overlapping POOL-sample windows over a frame of
// IN_COUNT signed samples, results queued through a two-entry skid buffer.
module maxpool_1d_stream
    import cnn_stream_pkg::*;
#(
    parameter int IN_COUNT = 25,
    parameter int POOL     = 2,
    parameter int PARTIAL  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] s_data_in_x,
    input  logic         s_valid_x,
    output logic         s_ready_x,
    output logic [T-1:0] m_data_out_y,
    output logic         m_valid_y,
    output logic         m_last_y,
    input  logic         m_ready_y
);

    localparam int CW = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
    localparam int WW = $clog2(POOL);
    // Sample index whose result carries last: the trailing partial window when
    // it is kept, otherwise the end of the last full window.
    localparam int LAST_IDX = (PARTIAL != 0) ? IN_COUNT - 1 : (IN_COUNT / POOL) * POOL - 1;

    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    sample_t       cur_max_q, cur_max_d;

    sample_t       x;
    sample_t       win_result;
    logic          accept, frame_end, win_done, push, buf_ready;
    beat_t         push_beat, out_beat;
    logic [T:0]    out_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q  <= '0;
            win_cnt_q <= '0;
            cur_max_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            win_cnt_q <= win_cnt_d;
            cur_max_q <= cur_max_d;
        end
    end

    always_comb begin
        x          = sample_t'(s_data_in_x);
        accept     = s_valid_x && buf_ready;
        frame_end  = (in_cnt_q == CW'(IN_COUNT - 1));
        win_done   = (win_cnt_q == WW'(POOL - 1));
        win_result = (win_cnt_q == '0) ? x : smax(cur_max_q, x);
        push       = accept && (win_done || ((PARTIAL != 0) && frame_end));
        push_beat  = '{data: win_result, last: (in_cnt_q == CW'(LAST_IDX))};

        in_cnt_d  = in_cnt_q;
        win_cnt_d = win_cnt_q;
        cur_max_d = cur_max_q;
        if (accept) begin
            in_cnt_d  = frame_end ? '0 : in_cnt_q + 1'b1;
            win_cnt_d = (win_done || frame_end) ? '0 : win_cnt_q + 1'b1;
            cur_max_d = win_result;
        end
    end

    skid_buf2 u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_beat (push_beat),
        .ready     (buf_ready),
        .m_valid   (m_valid_y),
        .m_beat    (out_bits),
        .m_ready   (m_ready_y)
    );

    always_comb begin
        out_beat     = beat_t'(out_bits);
        s_ready_x    = buf_ready;
        m_data_out_y = out_beat.data;
        m_last_y     = out_beat.last;
    end

endmodule

// File: tb/tb_maxpool_1d_stream.sv
// Directed bench for maxpool_1d_stream: one instance keeps the partial window,
// a second instance drops it.
module tb_maxpool_1d_stream;
    import cnn_stream_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [T-1:0] s_data_in_x;
    logic         s_valid_x;
    logic         sel_d;
    logic         m_ready_y;
    logic         rand_mode;

    logic         valid_p, valid_d;
    logic         ready_p, ready_d;
    logic [T-1:0] data_p, data_d;
    logic         mvalid_p, mvalid_d, last_p, last_d;

    int total_count = 0;
    int bad_count   = 0;
    int cycle       = 0;

    sample_t in_frame [25];
    sample_t exp_data [$];
    logic    exp_last [$];
    sample_t got_p_data [$];
    logic    got_p_last [$];
    int      got_p_cyc  [$];
    sample_t got_d_data [$];
    logic    got_d_last [$];

    always #5 clk = ~clk;

    assign valid_p = s_valid_x & ~sel_d;
    assign valid_d = s_valid_x & sel_d;

    maxpool_1d_stream #(.IN_COUNT(25), .POOL(2), .PARTIAL(1)) dut_p (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (valid_p),
        .s_ready_x    (ready_p),
        .m_data_out_y (data_p),
        .m_valid_y    (mvalid_p),
        .m_last_y     (last_p),
        .m_ready_y    (m_ready_y)
    );

    maxpool_1d_stream #(.IN_COUNT(25), .POOL(2), .PARTIAL(0)) dut_d (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (valid_d),
        .s_ready_x    (ready_d),
        .m_data_out_y (data_d),
        .m_valid_y    (mvalid_d),
        .m_last_y     (last_d),
        .m_ready_y    (1'b1)
    );

    always @(posedge clk) cycle <= cycle + 1;

    // Output monitor: a beat seen valid&ready at the negedge transfers on the next posedge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (mvalid_p && m_ready_y) begin
                got_p_data.push_back(sample_t'(data_p));
                got_p_last.push_back(last_p);
                got_p_cyc.push_back(cycle);
            end
            if (mvalid_d) begin
                got_d_data.push_back(sample_t'(data_d));
                got_d_last.push_back(last_d);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        total_count++;
        assert (observed === expected) else begin
            bad_count++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input sample_t v);
        int waited;
        s_data_in_x = v;
        s_valid_x   = 1'b1;
        waited      = 0;
        @(negedge clk);
        while (!(sel_d ? ready_d : ready_p) && waited < 300) begin
            @(posedge clk);
            #1;
            if (rand_mode) m_ready_y = 1'($urandom_range(0, 1));
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) checkOutput("send_timeout", 32'(sel_d ? ready_d : ready_p), 1);
        @(posedge clk);
        #1;
        if (rand_mode) m_ready_y = 1'($urandom_range(0, 1));
    endtask

    task automatic sendFrame();
        for (int i = 0; i < 25; i++) applyStimulus(in_frame[i]);
    endtask

    task automatic rampFrame();
        for (int i = 0; i < 25; i++) in_frame[i] = sample_t'(i + 1);
    endtask

    task automatic buildExpected(input bit partial, input bit append);
        sample_t mx;
        mx = '0;
        if (!append) begin
            exp_data.delete();
            exp_last.delete();
        end
        for (int i = 0; i < 25; i++) begin
            if (i % 2 == 0) mx = in_frame[i];
            else if (in_frame[i] > mx) mx = in_frame[i];
            if (i % 2 == 1) begin
                exp_data.push_back(mx);
                exp_last.push_back(!partial && i == 23);
            end
            if (i == 24 && partial) begin
                exp_data.push_back(mx);
                exp_last.push_back(1'b1);
            end
        end
    endtask

    task automatic clearGot();
        got_p_data.delete();
        got_p_last.delete();
        got_p_cyc.delete();
        got_d_data.delete();
        got_d_last.delete();
    endtask

    task automatic waitDrain(input int n, input bit use_d);
        int waited;
        waited = 0;
        while ((use_d ? got_d_data.size() : got_p_data.size()) < n && waited < 400) begin
            @(posedge clk);
            waited++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic checkQueue(input string tag, input bit use_d);
        int n;
        n = use_d ? got_d_data.size() : got_p_data.size();
        checkOutput({tag, "_count"}, n, exp_data.size());
        for (int i = 0; i < n && i < exp_data.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i),
                        use_d ? got_d_data[i] : got_p_data[i], exp_data[i]);
            checkOutput($sformatf("%s_last%0d", tag, i),
                        32'(use_d ? got_d_last[i] : got_p_last[i]), 32'(exp_last[i]));
        end
    endtask

    initial begin
        reset       = 1'b1;
        s_valid_x   = 1'b0;
        s_data_in_x = '0;
        sel_d       = 1'b0;
        m_ready_y   = 1'b1;
        rand_mode   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("rst_ready_p", 32'(ready_p), 1);
        checkOutput("rst_valid_p", 32'(mvalid_p), 0);
        checkOutput("rst_data_p", 32'(data_p), 0);
        checkOutput("rst_last_p", 32'(last_p), 0);
        checkOutput("rst_ready_d", 32'(ready_d), 1);
        checkOutput("rst_valid_d", 32'(mvalid_d), 0);

        $display("[TB] ramp frame, full throughput");
        rampFrame();
        buildExpected(1'b1, 1'b0);
        clearGot();
        applyStimulus(in_frame[0]);
        checkOutput("lat_first", 32'(mvalid_p), 0);
        applyStimulus(in_frame[1]);
        checkOutput("lat_valid", 32'(mvalid_p), 1);
        checkOutput("lat_data", sample_t'(data_p), 2);
        for (int i = 2; i < 25; i++) applyStimulus(in_frame[i]);
        s_valid_x = 1'b0;
        waitDrain(13, 1'b0);
        checkQueue("ramp", 1'b0);
        if (got_p_cyc.size() >= 12)
            for (int k = 0; k < 11; k++)
                checkOutput($sformatf("ramp_gap%0d", k), got_p_cyc[k+1] - got_p_cyc[k], 2);

        $display("[TB] signed extremes");
        rampFrame();
        in_frame[0] = sample_t'(-5);
        in_frame[1] = sample_t'(-3);
        in_frame[2] = sample_t'(-32768);
        in_frame[3] = sample_t'(32767);
        in_frame[4] = sample_t'(-1);
        in_frame[5] = sample_t'(-32768);
        buildExpected(1'b1, 1'b0);
        clearGot();
        sendFrame();
        s_valid_x = 1'b0;
        waitDrain(13, 1'b0);
        checkQueue("signed", 1'b0);
        if (got_p_data.size() >= 3) begin
            checkOutput("signed_w0", got_p_data[0], -3);
            checkOutput("signed_w1", got_p_data[1], 32767);
            checkOutput("signed_w2", got_p_data[2], -1);
        end

        $display("[TB] backpressure");
        rampFrame();
        buildExpected(1'b1, 1'b0);
        clearGot();
        m_ready_y = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(in_frame[i]);
        s_data_in_x = in_frame[4];
        checkOutput("bp_ready_drop", 32'(ready_p), 0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("bp_ready_held", 32'(ready_p), 0);
        checkOutput("bp_valid_held", 32'(mvalid_p), 1);
        checkOutput("bp_data_held", sample_t'(data_p), 2);
        checkOutput("bp_last_held", 32'(last_p), 0);
        m_ready_y = 1'b1;
        for (int i = 4; i < 25; i++) applyStimulus(in_frame[i]);
        s_valid_x = 1'b0;
        waitDrain(13, 1'b0);
        checkQueue("bp", 1'b0);

        $display("[TB] partial window dropped");
        sel_d = 1'b1;
        rampFrame();
        buildExpected(1'b0, 1'b0);
        clearGot();
        sendFrame();
        s_valid_x = 1'b0;
        waitDrain(12, 1'b1);
        checkQueue("drop", 1'b1);
        sel_d = 1'b0;

        $display("[TB] back-to-back frames, random downstream ready");
        rampFrame();
        buildExpected(1'b1, 1'b0);
        buildExpected(1'b1, 1'b1);
        clearGot();
        rand_mode = 1'b1;
        sendFrame();
        sendFrame();
        s_valid_x = 1'b0;
        rand_mode = 1'b0;
        m_ready_y = 1'b1;
        waitDrain(26, 1'b0);
        checkQueue("b2b", 1'b0);
        if (got_p_last.size() >= 26) begin
            checkOutput("b2b_last13", 32'(got_p_last[12]), 1);
            checkOutput("b2b_last26", 32'(got_p_last[25]), 1);
        end

        $display("[TB] reset mid-frame");
        rampFrame();
        m_ready_y = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(in_frame[i]);
        m_ready_y = 1'b0;
        applyStimulus(in_frame[5]);
        applyStimulus(in_frame[6]);
        s_valid_x = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_rst_valid", 32'(mvalid_p), 0);
        checkOutput("mid_rst_ready", 32'(ready_p), 1);
        clearGot();
        buildExpected(1'b1, 1'b0);
        m_ready_y = 1'b1;
        sendFrame();
        s_valid_x = 1'b0;
        waitDrain(13, 1'b0);
        checkQueue("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule
